// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dram_responder
//  Description : Single-outstanding DRAM-like memory responder. A request is
//                accepted in IDLE, held for LATENCY busy cycles, then answered
//                with a one-cycle data_data_ok pulse. Writes honour byte
//                enables; reads return the pre-write word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_responder #(
   parameter int MEM_AW  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wen,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok
);

   localparam int         c_words   = 2 ** MEM_AW;
   localparam logic [3:0] c_latency = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_wr;
   logic [3:0]          r_wen;
   logic [1:0]          r_size;
   logic [MEM_AW-1:0]   r_idx;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic                r_data_ok;
   logic [31:0]         r_mem [c_words];

   logic                w_idle;
   logic                w_accept;
   logic                w_enter_resp;
   logic [MEM_AW-1:0]   w_in_idx;
   logic                w_sel_wr;
   logic [3:0]          w_sel_wen;
   logic [MEM_AW-1:0]   w_sel_idx;
   logic [31:0]         w_sel_wdata;
   logic                w_unused;

   // Word index ignores the byte offset and any address bits above the store.
   assign w_in_idx = data_addr[MEM_AW+1:2];
   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = w_idle & data_req & ~rst;

   // RESP is entered straight from an accept when LATENCY is zero, otherwise
   // from the last BUSY cycle.
   assign w_enter_resp = w_accept ? (c_latency == 4'd0)
                                  : (~rst & (r_state == ST_BUSY) & (r_cnt <= 4'd1));

   // On a zero-latency accept the commit happens on the accept edge itself,
   // so the live inputs are used instead of the not-yet-latched copies.
   assign w_sel_wr    = w_idle ? data_wr    : r_wr;
   assign w_sel_wen   = w_idle ? data_wen   : r_wen;
   assign w_sel_idx   = w_idle ? w_in_idx   : r_idx;
   assign w_sel_wdata = w_idle ? data_wdata : r_wdata;

   assign data_addr_ok = w_accept;
   assign data_data_ok = r_data_ok;
   assign data_rdata   = r_rdata;

   // Transfer size and the ignored address bits are carried but never decoded.
   assign w_unused = ^{r_size, data_addr[31:MEM_AW+2], data_addr[1:0]};

   // Control FSM: accept, latency countdown, response pulse and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_data_ok <= 1'b0;
         r_rdata   <= 32'h0;
         r_wr      <= 1'b0;
         r_wen     <= 4'h0;
         r_size    <= 2'd0;
         r_idx     <= '0;
         r_wdata   <= 32'h0;
      end else begin
         r_data_ok <= w_enter_resp;
         if (w_enter_resp && !w_sel_wr) begin
            r_rdata <= r_mem[w_sel_idx];
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_wr    <= data_wr;
                  r_wen   <= data_wen;
                  r_size  <= data_size;
                  r_idx   <= w_in_idx;
                  r_wdata <= data_wdata;
                  r_cnt   <= c_latency;
                  r_state <= (c_latency == 4'd0) ? ST_RESP : ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Backing store: byte-enabled write on the edge entering RESP; not reset.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_sel_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_sel_wen[b]) begin
               r_mem[w_sel_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_responder
//  Description : Self-checking bench for dram_responder. Unit 0 runs with
//                LATENCY=2, unit 1 with LATENCY=0. Directed table, handshake
//                corner sequences and randomized traffic against a word-level
//                memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_responder;

   logic        clk;
   logic        rst      [2];
   logic        req      [2];
   logic        wr       [2];
   logic [3:0]  wen      [2];
   logic [1:0]  size     [2];
   logic [31:0] addr     [2];
   logic [31:0] wdata    [2];
   logic [31:0] rdata    [2];
   logic        addr_ok  [2];
   logic        data_ok  [2];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // Behavioural model: memory words per unit and last read value per unit.
   logic [31:0] mdl     [2][1024];
   logic [31:0] last_rd [2];

   dram_responder #(.MEM_AW(10), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_wr(wr[0]),
      .data_wen(wen[0]), .data_size(size[0]), .data_addr(addr[0]),
      .data_wdata(wdata[0]), .data_rdata(rdata[0]),
      .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0])
   );

   dram_responder #(.MEM_AW(10), .LATENCY(0)) u_dut_l0 (
      .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_wr(wr[1]),
      .data_wen(wen[1]), .data_size(size[1]), .data_addr(addr[1]),
      .data_wdata(wdata[1]), .data_rdata(rdata[1]),
      .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
   endtask

   // Model step: returns the rdata value expected at data_data_ok.
   function automatic logic [31:0] model_step(input int u, input logic w, input logic [3:0] e,
                                              input logic [31:0] a, input logic [31:0] d);
      int idx;
      logic [31:0] old;
      idx = int'((a / 4) % 1024);
      old = mdl[u][idx];
      if (w) begin
         for (int b = 0; b < 4; b++)
            if (e[b]) old[8*b +: 8] = d[8*b +: 8];
         mdl[u][idx] = old;
      end else begin
         last_rd[u] = old;
      end
      return last_rd[u];
   endfunction

   // One complete transaction; inputs are scrambled after accept.
   task automatic do_txn(input int u, input logic w, input logic [3:0] e,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
      int   cyc;
      logic seen;
      @(negedge clk);
      req[u] = 1'b1; wr[u] = w; wen[u] = e; addr[u] = a; wdata[u] = d;
      size[u] = 2'($urandom);
      #1;
      chk("accept_addr_ok", 32'(addr_ok[u]), 32'd1);
      @(posedge clk);
      seen = 1'b0; cyc = 0; got = 32'h0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         wr[u] = 1'($urandom); wen[u] = 4'($urandom);
         addr[u] = $urandom; wdata[u] = $urandom;
         #1;
         chk("no_reaccept", 32'(addr_ok[u]), 32'd0);
         if (data_ok[u]) begin
            seen = 1'b1;
            got  = rdata[u];
         end
      end
      chk("latency", 32'(cyc), 32'(lat_of(u) + 1));
      req[u] = 1'b0;
      @(negedge clk);
      #1;
      chk("data_ok_pulse", 32'(data_ok[u]), 32'd0);
   endtask

   typedef struct {
      int          u;
      logic        w;
      logic [3:0]  e;
      logic [31:0] a;
      logic [31:0] d;
      logic        chk_rd;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [13];
   logic [31:0] got;
   logic [31:0] expv;

   initial begin
      tbl[0]  = '{0, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{0, 1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF};
      tbl[2]  = '{0, 1'b1, 4'hF, 32'h20,   32'h11223344, 1'b0, 32'h0};
      tbl[3]  = '{0, 1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 1'b0, 32'h0};
      tbl[4]  = '{0, 1'b0, 4'h0, 32'h20,   32'h0,        1'b1, 32'h11BB33DD};
      tbl[5]  = '{0, 1'b1, 4'hF, 32'h40,   32'h55555555, 1'b0, 32'h0};
      tbl[6]  = '{0, 1'b1, 4'h0, 32'h40,   32'h12345678, 1'b0, 32'h0};
      tbl[7]  = '{0, 1'b0, 4'h0, 32'h40,   32'h0,        1'b1, 32'h55555555};
      tbl[8]  = '{1, 1'b1, 4'hF, 32'h4,    32'h12345678, 1'b0, 32'h0};
      tbl[9]  = '{1, 1'b0, 4'h0, 32'h4,    32'h0,        1'b1, 32'h12345678};
      tbl[10] = '{1, 1'b0, 4'h0, 32'h1004, 32'h0,        1'b1, 32'h12345678};
      tbl[11] = '{0, 1'b1, 4'hF, 32'h30,   32'h0,        1'b0, 32'h0};
      tbl[12] = '{1, 1'b1, 4'hF, 32'h30,   32'h0,        1'b0, 32'h0};

      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b1; req[u] = 1'b1; wr[u] = 1'b0; wen[u] = 4'h0; size[u] = 2'd0;
         addr[u] = 32'h0; wdata[u] = 32'h0; last_rd[u] = 32'h0;
      end

      // Reset state, with a request pending that must not be accepted.
      repeat (3) begin
         @(negedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            chk("rst_addr_ok", 32'(addr_ok[u]), 32'd0);
            chk("rst_data_ok", 32'(data_ok[u]), 32'd0);
            chk("rst_rdata", rdata[u], 32'h0);
         end
      end
      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b0; req[u] = 1'b0;
      end

      // Idle without a request: no handshakes.
      repeat (2) begin
         @(negedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            chk("idle_addr_ok", 32'(addr_ok[u]), 32'd0);
            chk("idle_data_ok", 32'(data_ok[u]), 32'd0);
         end
      end

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         do_txn(tbl[i].u, tbl[i].w, tbl[i].e, tbl[i].a, tbl[i].d, got);
         expv = model_step(tbl[i].u, tbl[i].w, tbl[i].e, tbl[i].a, tbl[i].d);
         chk("tbl_model_rdata", got, expv);
         if (tbl[i].chk_rd) chk("tbl_rdata", got, tbl[i].exp);
      end

      // Request held high across back-to-back reads: accept every L+2 cycles.
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b0; wen[0] = 4'h0; addr[0] = 32'h10; wdata[0] = 32'h0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("held_addr_ok", 32'(addr_ok[0]), 32'((c % 4) == 0));
         chk("held_data_ok", 32'(data_ok[0]), 32'((c % 4) == 3));
         if ((c % 4) == 3) chk("held_rdata", rdata[0], mdl[0][4]);
         @(negedge clk);
      end
      req[0] = 1'b0;
      repeat (4) @(negedge clk);
      last_rd[0] = mdl[0][4];

      // Reset during BUSY aborts a write to 0x30.
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D;
      #1;
      chk("abort_accept", 32'(addr_ok[0]), 32'd1);
      @(negedge clk);
      rst[0] = 1'b1;
      #1;
      chk("abort_busy_data_ok", 32'(data_ok[0]), 32'd0);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("abort_rst_data_ok", 32'(data_ok[0]), 32'd0);
         chk("abort_rst_addr_ok", 32'(addr_ok[0]), 32'd0);
         chk("abort_rst_rdata", rdata[0], 32'h0);
      end
      rst[0] = 1'b0; req[0] = 1'b0;
      last_rd[0] = 32'h0;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("abort_no_data_ok", 32'(data_ok[0]), 32'd0);
      end
      do_txn(0, 1'b0, 4'h0, 32'h30, 32'h0, got);
      expv = model_step(0, 1'b0, 4'h0, 32'h30, 32'h0);
      chk("abort_read_30", got, 32'h0);
      chk("abort_model_30", got, expv);

      // Randomized traffic over a small, pre-initialized word set with aliasing.
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'((100 + k) * 4);
            d = $urandom;
            do_txn(u, 1'b1, 4'hF, a, d, got);
            expv = model_step(u, 1'b1, 4'hF, a, d);
            chk("rnd_init", got, expv);
         end
      end
      for (int n = 0; n < 60; n++) begin
         int          u;
         logic        w;
         logic [3:0]  e;
         logic [31:0] a;
         logic [31:0] d;
         u = int'($urandom_range(0, 1));
         w = 1'($urandom);
         e = 4'($urandom);
         a = ($urandom & 32'hFFFF_F003) | 32'((100 + int'($urandom_range(0, 7))) * 4);
         d = $urandom;
         do_txn(u, w, e, a, d, got);
         expv = model_step(u, w, e, a, d);
         chk("rnd_rdata", got, expv);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter MEM_AW, default 10: word-address width of the backing store (2^MEM_AW 32-bit words).
REQ-002 Parameter LATENCY, default 2: number of BUSY cycles between accept and response; legal range 0..15.
REQ-003 The clock SHALL be port clk: input, 1 bit, single clock, all state updates on posedge.
REQ-004 The reset SHALL be port rst: input, 1 bit, synchronous, active-high.
REQ-005 Port data_req: input, 1 bit; initiator request, held high until data_data_ok.
REQ-006 Port data_wr: input, 1 bit; 1 = write, 0 = read.
REQ-007 Port data_wen: input, 4 bits; byte enables, bit3 = [31:24] ... bit0 = [7:0].
REQ-008 Port data_size: input, 2 bits; transfer size, captured at accept but otherwise ignored.
REQ-009 Port data_addr: input, 32 bits; byte address.
REQ-010 Port data_wdata: input, 32 bits; write data.
REQ-011 Port data_rdata: output, 32 bits; read data, registered.
REQ-012 Port data_addr_ok: output, 1 bit; request accepted this cycle.
REQ-013 Port data_data_ok: output, 1 bit; transaction complete this cycle, one-cycle pulse.

Function
REQ-014 Backing store SHALL be 2^MEM_AW x 32-bit words, indexed by data_addr[MEM_AW+1:2].
- Address bits [1:0] and [31:MEM_AW+2] are ignored; upper addresses alias.
REQ-015 FSM states SHALL be IDLE, BUSY and RESP; at most one transaction is outstanding.
REQ-016 data_addr_ok SHALL be combinational: (state==IDLE) & data_req & ~rst.
REQ-017 Accept edge: in IDLE with data_addr_ok=1, the block SHALL latch wr, wen, size, word index and wdata, and load the counter with LATENCY.
- If LATENCY==0, next state is RESP; otherwise next state is BUSY.
REQ-018 BUSY SHALL decrement the counter each cycle and move to RESP on the edge where counter==1.
REQ-019 Commit: on the edge entering RESP, a latched write SHALL update only the bytes whose wen bit is 1.
- The same edge SHALL load data_rdata for a read with mem[index], using the pre-write contents.
REQ-020 In RESP, data_data_ok SHALL be 1 for exactly one cycle; the next state is IDLE unconditionally.
REQ-021 Accept-to-data_data_ok latency SHALL be LATENCY+1 cycles; addr_ok-to-addr_ok spacing is at least LATENCY+2 cycles.
REQ-022 data_req high while the FSM is in BUSY or RESP SHALL NOT be re-accepted; data_addr_ok stays 0.
REQ-023 Input changes after the accept edge SHALL NOT affect the outstanding transaction.
REQ-024 data_rdata SHALL hold its value across writes and idle cycles; only reads update it.
REQ-025 A write with wen=4'b0000 SHALL complete normally (data_data_ok pulses) with no memory change.
REQ-026 In IDLE with data_req=0, the FSM SHALL remain in IDLE and both handshake outputs SHALL be 0.
REQ-027 A request in the cycle immediately after data_data_ok SHALL be accepted in that cycle, since the FSM is already in IDLE.
REQ-028 Read-after-write to the same word in back-to-back transactions SHALL return the newly written data.

Reset
REQ-029 While rst=1: state=IDLE, counter=0, data_addr_ok=0, data_data_ok=0, data_rdata=32'h0.
REQ-030 Reset in BUSY SHALL abort the transaction: no write commit, no data_data_ok.
REQ-031 Reset in RESP SHALL clear data_data_ok on the following cycle; a write committed on entry to RESP is retained.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, wen 1111 -> addr_ok in accept cycle, data_ok 3 cycles later; then read 0x10 -> rdata 0xDEADBEEF with data_ok.
REQ-034 Partial write: write 0x11223344 to addr 0x20 with wen 1111, then write 0xAABBCCDD with wen 0101, then read 0x20 -> 0x11BB33DD.
REQ-035 Hold req high for 10 cycles through one read, LATENCY=2 -> exactly one addr_ok pulse before data_ok; a second addr_ok appears in the cycle after data_ok.
REQ-036 LATENCY=0: read addr 0x4 -> data_ok exactly 1 cycle after accept; aliasing check: with MEM_AW=10, addr 0x1004 returns the same data as 0x4.
REQ-037 Start a write of 0xCAFEF00D to addr 0x30 (old value 0x0), assert rst one cycle later during BUSY -> no data_ok; after reset a read of 0x30 returns 0x0 and rdata reads 0x0 during reset.
REQ-038 Write with wen 0000 to addr 0x40 holding 0x55555555 -> data_ok pulses; a read of 0x40 returns 0x55555555.
